// File: rtl/lisnoc_dma_wbprogrammer_pkg.sv
// Shared definitions for the LISNoC DMA request-table programmer:
// controller states and the byte offsets of the words inside one table entry.
package lisnoc_dma_wbprogrammer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_GAP,
        ST_POLL,
        ST_RESP
    } state_t;

    localparam logic [31:0] DMA_OFF_LADDR = 32'h00;
    localparam logic [31:0] DMA_OFF_SIZE  = 32'h04;
    localparam logic [31:0] DMA_OFF_RTILE = 32'h08;
    localparam logic [31:0] DMA_OFF_RADDR = 32'h0C;
    localparam logic [31:0] DMA_OFF_DIR   = 32'h10;
    localparam logic [31:0] DMA_OFF_VALID = 32'h14;

    // Byte distance between two consecutive table entries
    localparam int unsigned DMA_ENTRY_STRIDE = 32;

    // Index of the last word written per request (the valid word)
    localparam logic [2:0] DMA_LAST_WORD = 3'd5;

    // Offset of descriptor word w inside an entry
    function automatic logic [31:0] word_offset(input logic [2:0] w);
        case (w)
            3'd0:    return DMA_OFF_LADDR;
            3'd1:    return DMA_OFF_SIZE;
            3'd2:    return DMA_OFF_RTILE;
            3'd3:    return DMA_OFF_RADDR;
            3'd4:    return DMA_OFF_DIR;
            default: return DMA_OFF_VALID;
        endcase
    endfunction

endpackage

// File: rtl/lisnoc_dma_wbprogrammer.sv
// Wishbone classic master that writes one LISNoC DMA request-table entry
// (five descriptor words plus the valid word) and then polls the entry's
// done bit until completion or until the poll limit is reached.
module lisnoc_dma_wbprogrammer
    import lisnoc_dma_wbprogrammer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0,
    parameter int unsigned TABLE_ENTRIES = 4,
    parameter int unsigned POLL_GAP      = 8,
    parameter int unsigned POLL_MAX      = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_slot,
    input  logic [31:0] req_laddr,
    input  logic [31:0] req_size,
    input  logic [31:0] req_rtile,
    input  logic [31:0] req_raddr,
    input  logic        req_dir,

    output logic        cpl_valid,
    input  logic        cpl_ready,
    output logic [1:0]  cpl_slot,
    output logic        cpl_timeout,

    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    localparam logic [1:0]  SLOT_MASK  = 2'(TABLE_ENTRIES - 1);
    localparam logic [31:0] GAP_LAST   = 32'(POLL_GAP - 1);
    localparam logic [31:0] POLL_LIMIT = 32'(POLL_MAX);

    state_t      state;
    logic [1:0]  slot_q;
    logic [31:0] base_q;
    logic [31:0] size_q;
    logic [31:0] rtile_q;
    logic [31:0] raddr_q;
    logic        dir_q;
    logic [2:0]  word;
    logic [31:0] gap_cnt;
    logic [31:0] poll_cnt;

    logic [31:0] entry_base;
    logic [31:0] next_data;
    logic [31:0] poll_inc;
    logic        bus_ack;
    logic        unused_dat;

    assign wb_sel_o   = 4'hf;
    assign bus_ack    = wb_cyc_o & wb_ack_i;
    assign unused_dat = ^wb_dat_i[31:1];

    // Entry address of the incoming request, data of the word following the
    // current one, and the saturating next poll count
    always_comb begin
        entry_base = BASE_ADDR + {25'b0, req_slot & SLOT_MASK, 5'b0};
        case (word)
            3'd0:    next_data = size_q;
            3'd1:    next_data = rtile_q;
            3'd2:    next_data = raddr_q;
            3'd3:    next_data = {31'b0, dir_q};
            3'd4:    next_data = 32'h1;
            default: next_data = '0;
        endcase
        poll_inc = (poll_cnt == '1) ? poll_cnt : poll_cnt + 32'd1;
    end

    // Controller FSM; all bus and handshake outputs are registered here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            req_ready   <= 1'b1;
            cpl_valid   <= 1'b0;
            cpl_slot    <= '0;
            cpl_timeout <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            slot_q      <= '0;
            base_q      <= '0;
            size_q      <= '0;
            rtile_q     <= '0;
            raddr_q     <= '0;
            dir_q       <= 1'b0;
            word        <= '0;
            gap_cnt     <= '0;
            poll_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        // laddr goes straight onto the bus, so it needs no copy
                        slot_q    <= req_slot & SLOT_MASK;
                        base_q    <= entry_base;
                        size_q    <= req_size;
                        rtile_q   <= req_rtile;
                        raddr_q   <= req_raddr;
                        dir_q     <= req_dir;
                        word      <= '0;
                        poll_cnt  <= '0;
                        wb_adr_o  <= entry_base + DMA_OFF_LADDR;
                        wb_dat_o  <= req_laddr;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        wb_we_o   <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (bus_ack) begin
                        if (word != DMA_LAST_WORD) begin
                            word     <= word + 3'd1;
                            wb_adr_o <= base_q + word_offset(word + 3'd1);
                            wb_dat_o <= next_data;
                        end else begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            wb_we_o  <= 1'b0;
                            gap_cnt  <= '0;
                            state    <= ST_GAP;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        wb_adr_o <= base_q + DMA_OFF_VALID;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= 1'b0;
                        state    <= ST_POLL;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end

                ST_POLL: begin
                    if (bus_ack) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (wb_dat_i[0]) begin
                            cpl_valid   <= 1'b1;
                            cpl_slot    <= slot_q;
                            cpl_timeout <= 1'b0;
                            state       <= ST_RESP;
                        end else begin
                            poll_cnt <= poll_inc;
                            if (POLL_MAX != 0 && poll_inc == POLL_LIMIT) begin
                                cpl_valid   <= 1'b1;
                                cpl_slot    <= slot_q;
                                cpl_timeout <= 1'b1;
                                state       <= ST_RESP;
                            end else begin
                                gap_cnt <= '0;
                                state   <= ST_GAP;
                            end
                        end
                    end
                end

                ST_RESP: begin
                    if (cpl_ready) begin
                        cpl_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lisnoc_dma_wbprogrammer.sv
// Bench for lisnoc_dma_wbprogrammer: a Wishbone slave with configurable wait
// states and done behaviour, a scoreboard of expected bus transactions and
// completions, and a monitor that checks them as the DUT produces them.
module tb_lisnoc_dma_wbprogrammer;

    localparam logic [31:0] BASE     = 32'h0;
    localparam int          POLL_GAP = 8;
    localparam int          POLL_MAX = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_slot;
    logic [31:0] req_laddr;
    logic [31:0] req_size;
    logic [31:0] req_rtile;
    logic [31:0] req_raddr;
    logic        req_dir;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [1:0]  cpl_slot;
    logic        cpl_timeout;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    lisnoc_dma_wbprogrammer #(
        .BASE_ADDR    (BASE),
        .TABLE_ENTRIES(4),
        .POLL_GAP     (POLL_GAP),
        .POLL_MAX     (POLL_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_slot   (req_slot),
        .req_laddr  (req_laddr),
        .req_size   (req_size),
        .req_rtile  (req_rtile),
        .req_raddr  (req_raddr),
        .req_dir    (req_dir),
        .cpl_valid  (cpl_valid),
        .cpl_ready  (cpl_ready),
        .cpl_slot   (cpl_slot),
        .cpl_timeout(cpl_timeout),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          idx;
    } bus_t;

    typedef struct {
        logic [1:0] slot;
        logic       to;
    } cpl_t;

    bus_t exp_bus[$];
    cpl_t exp_cpl[$];

    int tests = 0;
    int fails = 0;
    int bus_cnt = 0;
    int t_first = 0;
    int t_last = 0;
    bit prev_pending = 0;
    bit abort = 0;

    // Slave configuration (set by the driver between requests)
    int waits = 0;
    int done_after = 1;
    bit spur_en = 0;

    // Slave state
    int          cycle = 0;
    int          wcnt = 0;
    int          rd_cnt = 0;
    logic        spur = 1'b0;
    logic [31:0] junk = '0;
    logic        done_bit;

    assign done_bit = (done_after != 0) && (rd_cnt + 1 >= done_after);
    assign wb_dat_i = {junk[31:1], done_bit};
    assign wb_ack_i = (wb_cyc_o && wb_stb_o && wcnt == waits) || (spur && !wb_cyc_o);

    // Wait-state counter, read counter per request, stray acks outside cycles
    always @(posedge clk) begin
        cycle <= cycle + 1;
        spur  <= spur_en && ($urandom_range(0, 3) == 0);
        junk  <= $urandom;
        if (wb_cyc_o && wb_stb_o) begin
            if (wb_ack_i) begin
                wcnt <= 0;
                if (wb_we_o) rd_cnt <= 0;
                else         rd_cnt <= rd_cnt + 1;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        bit          pend = 0;
        bit          in_acc = 0;
        bit          cpl_seen = 0;
        int          idle = 0;
        logic [31:0] p_adr = '0;
        logic [31:0] p_dat = '0;
        logic        p_we = 1'b0;
        bus_t        e;
        cpl_t        c;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 0;
                in_acc = 0;
                cpl_seen = 0;
                continue;
            end
            if (wb_cyc_o && wb_stb_o) begin
                if (pend) begin
                    check("hold_adr", wb_adr_o, p_adr);
                    check("hold_dat", wb_dat_o, p_dat);
                    check("hold_we", 32'(wb_we_o), 32'(p_we));
                end
                if (!in_acc && !wb_we_o)
                    check("poll_gap", 32'(idle >= POLL_GAP), 32'd1);
                in_acc = 1;
                if (wb_ack_i) begin
                    bus_cnt++;
                    if (exp_bus.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_bus: got we=%0b adr=%h dat=%h expected no access",
                                 wb_we_o, wb_adr_o, wb_dat_o);
                    end else begin
                        e = exp_bus.pop_front();
                        check("bus_we", 32'(wb_we_o), 32'(e.we));
                        check("bus_adr", wb_adr_o, e.adr);
                        check("bus_sel", 32'(wb_sel_o), 32'hf);
                        if (e.we) check("bus_dat", wb_dat_o, e.dat);
                        if (e.idx == 0) t_first = cycle;
                        if (e.idx == 5) t_last = cycle;
                    end
                    pend = 0;
                    in_acc = 0;
                    idle = 0;
                end else begin
                    pend = 1;
                    p_adr = wb_adr_o;
                    p_dat = wb_dat_o;
                    p_we = wb_we_o;
                end
            end else begin
                idle++;
                pend = 0;
                in_acc = 0;
            end
            if (cpl_valid && !cpl_seen) begin
                cpl_seen = 1;
                check("polls_done", 32'(exp_bus.size()), 32'd0);
                if (exp_cpl.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_cpl: got slot=%0d expected no completion", cpl_slot);
                end else begin
                    c = exp_cpl.pop_front();
                    check("cpl_slot", 32'(cpl_slot), 32'(c.slot));
                    check("cpl_timeout", 32'(cpl_timeout), 32'(c.to));
                end
            end
            if (!cpl_valid) cpl_seen = 0;
        end
    endtask

    // Reference model: the entry is six word writes in offset order, then
    // polls until the done-th read or until POLL_MAX reads have been made
    task automatic push_expected(input logic [1:0] slot, input logic [31:0] la,
                                 input logic [31:0] sz, input logic [31:0] rt,
                                 input logic [31:0] ra, input logic dir,
                                 input int da, input bit with_polls);
        logic [31:0] base;
        logic [31:0] words[6];
        int          n;
        bit          to;
        base = BASE + 32'(slot) * 32;
        words[0] = la;
        words[1] = sz;
        words[2] = rt;
        words[3] = ra;
        words[4] = {31'b0, dir};
        words[5] = 32'h1;
        for (int i = 0; i < 6; i++)
            exp_bus.push_back('{we: 1'b1, adr: base + 32'(4 * i), dat: words[i], idx: i});
        if (with_polls) begin
            if (da >= 1 && da <= POLL_MAX) begin
                n = da;
                to = 0;
            end else begin
                n = POLL_MAX;
                to = 1;
            end
            for (int k = 0; k < n; k++)
                exp_bus.push_back('{we: 1'b0, adr: base + 32'h14, dat: '0, idx: 6 + k});
            exp_cpl.push_back('{slot: slot, to: to});
        end
    endtask

    task automatic present(input logic [1:0] slot, input logic [31:0] la, input logic [31:0] sz,
                           input logic [31:0] rt, input logic [31:0] ra, input logic dir);
        req_slot = slot;
        req_laddr = la;
        req_size = sz;
        req_rtile = rt;
        req_raddr = ra;
        req_dir = dir;
        req_valid = 1'b1;
    endtask

    task automatic run_req(input logic [1:0] slot, input logic [31:0] la, input logic [31:0] sz,
                           input logic [31:0] rt, input logic [31:0] ra, input logic dir,
                           input int w, input int da, input int hold);
        int budget;
        if (abort) return;
        if (!prev_pending) @(negedge clk);
        present(slot, la, sz, rt, ra, dir);
        if (prev_pending) begin
            check("busy_no_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1 cpl_ready = 1'b0;
            @(negedge clk);
            check("ready_after_cpl", 32'(req_ready), 32'd1);
            check("cpl_valid_drop", 32'(cpl_valid), 32'd0);
        end else begin
            check("idle_ready", 32'(req_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        waits = w;
        done_after = da;
        spur_en = ($urandom_range(0, 1) == 1);
        prev_pending = 0;
        push_expected(slot, la, sz, rt, ra, dir, da, 1);
        @(negedge clk);
        check("ready_low_busy", 32'(req_ready), 32'd0);
        budget = 3000;
        while (!cpl_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!cpl_valid) begin
            tests++;
            fails++;
            $display("FAIL cpl_wait: got no completion within 3000 cycles expected cpl_valid=1");
            abort = 1;
            return;
        end
        check("write_span", 32'(t_last - t_first), 32'(5 * (w + 1)));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_cpl_valid", 32'(cpl_valid), 32'd1);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_bus_idle", 32'(wb_cyc_o), 32'd0);
        end
        cpl_ready = 1'b1;
        prev_pending = 1;
    endtask

    task automatic close_pending();
        if (!prev_pending || abort) return;
        @(posedge clk);
        #1 cpl_ready = 1'b0;
        prev_pending = 0;
        @(negedge clk);
        check("final_ready", 32'(req_ready), 32'd1);
        check("final_cpl_valid", 32'(cpl_valid), 32'd0);
    endtask

    task automatic reset_test();
        int          budget;
        int          snap;
        logic [31:0] base;
        if (abort) return;
        @(negedge clk);
        present(2'd1, 32'hA5A5_0000, 32'h20, 32'h7, 32'hB000, 1'b0);
        base = BASE + 32'h20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        waits = 1;
        done_after = 1;
        spur_en = 0;
        push_expected(2'd1, 32'hA5A5_0000, 32'h20, 32'h7, 32'hB000, 1'b0, 1, 0);
        budget = 200;
        do begin
            @(negedge clk);
            budget--;
        end while (!(wb_cyc_o && wb_stb_o && wb_we_o && wb_adr_o == base + 32'h0C) && budget > 0);
        check("reach_word3", 32'(wb_adr_o), base + 32'h0C);
        #2 rst = 1'b0;
        #1;
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_we", 32'(wb_we_o), 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_cpl_valid", 32'(cpl_valid), 32'd0);
        exp_bus.delete();
        exp_cpl.delete();
        snap = bus_cnt;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (40) @(negedge clk);
        check("no_bus_after_reset", 32'(bus_cnt), 32'(snap));
        check("idle_after_reset", 32'(req_ready), 32'd1);
    endtask

    task automatic run_all();
        // Directed cases
        run_req(2'd2, 32'h1000, 32'h10, 32'h3, 32'h2000, 1'b1, 0, 3, 0);
        run_req(2'd1, 32'hDEAD_BEEF, 32'h4, 32'h9, 32'h1234_5678, 1'b0, 3, 1, 1);
        run_req(2'd3, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h8, 1'b1, 1, 0, 0);
        run_req(2'd0, 32'h40, 32'h2, 32'h5, 32'h80, 1'b0, 0, 2, 10);
        // Randomized requests
        for (int i = 0; i < 16; i++)
            run_req(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                    1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 5),
                    $urandom_range(0, 3));
        close_pending();
        reset_test();
        run_req(2'd2, 32'h55AA, 32'h1, 32'h2, 32'h3, 1'b1, 2, 2, 0);
        close_pending();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        cpl_ready = 1'b0;
        req_slot = '0;
        req_laddr = '0;
        req_size = '0;
        req_rtile = '0;
        req_raddr = '0;
        req_dir = 1'b0;
        #1 rst = 1'b0;
        #2;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_cpl_valid", 32'(cpl_valid), 32'd0);
        check("reset_cpl_timeout", 32'(cpl_timeout), 32'd0);
        check("reset_cpl_slot", 32'(cpl_slot), 32'd0);
        check("reset_cyc", 32'(wb_cyc_o), 32'd0);
        check("reset_stb", 32'(wb_stb_o), 32'd0);
        check("reset_we", 32'(wb_we_o), 32'd0);
        check("reset_adr", wb_adr_o, 32'd0);
        check("reset_dat", wb_dat_o, 32'd0);
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        fork
            run_all();
            begin
                #2_000_000;
                tests++;
                fails++;
                $display("FAIL watchdog: got simulation time limit expected completion of all requests");
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
